// File: rtl/teak_mutex_n_if.sv
// -----------------------------------------------------------------------------
// teak_mutex_n_if
// Handshake bundle between N four-phase requesters and the teak_mutex_n
// arbiter.
//
//   req     N    four-phase request, one bit per channel (requester -> arbiter)
//   gnt     N    four-phase grant, one-hot or zero      (arbiter -> requester)
//   gnt_id  GW   index of current / most recent grantee (arbiter -> requester)
//   busy    1    high while any gnt bit is high          (arbiter -> requester)
//
// Modports:
//   master  the requester side (drives req)
//   slave   the arbiter side   (drives gnt, gnt_id, busy)
// -----------------------------------------------------------------------------
interface teak_mutex_n_if #(
    parameter int N = 2
);
    localparam int GW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [GW-1:0] gnt_id;
    logic          busy;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/teak_mutex_n.sv
// -----------------------------------------------------------------------------
// teak_mutex_n
// Clocked N-way mutual-exclusion arbiter with four-phase (return-to-zero)
// request/grant handshakes and round-robin fairness. At most one channel is
// granted at a time, and every grant is separated from the next by at least
// one cycle with all grants low.
//
// Parameters:
//   N            number of channels, 2..16
//   SYNC_STAGES  synchroniser depth per request bit (>= 2), only used when
//                TEAK_MUTEX_SYNC_EN is defined
//
// Ports:
//   clk      single clock, all state changes on its rising edge
//   reset_n  asynchronous active-low reset
//   bus      teak_mutex_n_if.slave: req in, gnt / gnt_id / busy out
//
// Configuration macro:
//   TEAK_MUTEX_SYNC_EN  when defined, each req bit passes through a
//                       SYNC_STAGES-deep flop chain so req may be fully
//                       asynchronous to clk. When undefined, req is used
//                       directly and must be synchronous to clk.
// -----------------------------------------------------------------------------
module teak_mutex_n #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    teak_mutex_n_if.slave  bus
);
    localparam int GW = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_r;
    logic [N-1:0]  gnt_r;
    logic [GW-1:0] gnt_id_r;
    logic          busy_r;
    logic [GW-1:0] ptr_r;

    logic [N-1:0]  r_s;
    logic [GW:0]   win_s;
    logic          win_valid_s;
    logic [GW-1:0] win_idx_s;

    // First set bit of r scanning upward from p, wrapping past N-1 to 0.
    // Result is {found, index}.
    function automatic logic [GW:0] find_winner(input logic [N-1:0]  r,
                                                 input logic [GW-1:0] p);
        logic          found;
        logic [GW-1:0] w;
        int            idx;
        found = 1'b0;
        w     = {GW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = GW'(idx);
            end else begin
                found = found;
            end
        end
        return {found, w};
    endfunction

    // Round-robin pointer advance: (w + 1) mod N.
    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] w);
        int n;
        n = (int'(w) + 1) % N;
        return GW'(n);
    endfunction

    // One-hot grant vector for channel w.
    function automatic logic [N-1:0] onehot(input logic [GW-1:0] w);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[w] = 1'b1;
        return v;
    endfunction

    // Illegal synchroniser depth: nothing is built, the block only marks it.
    if (SYNC_STAGES < 2) begin : g_sync_stages_below_minimum
    end

`ifdef TEAK_MUTEX_SYNC_EN
    logic [N-1:0] sync_r [SYNC_STAGES];

    // Request synchroniser chain; stage 0 captures the raw asynchronous req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {N{1'b0}};
            end
        end else begin
            sync_r[0] <= bus.req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign r_s = sync_r[SYNC_STAGES-1];
`else
    assign r_s = bus.req;
`endif

    assign win_s       = find_winner(r_s, ptr_r);
    assign win_valid_s = win_s[GW];
    assign win_idx_s   = win_s[GW-1:0];

    // Arbitration FSM with registered grant outputs.
    // Release is detected by masking r with the held grant, so a release and a
    // new request in the same cycle only take the release; arbitration for the
    // pending request happens from IDLE on the following edge, which also
    // guarantees the all-low gap between grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            gnt_r    <= {N{1'b0}};
            gnt_id_r <= {GW{1'b0}};
            busy_r   <= 1'b0;
            ptr_r    <= {GW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        gnt_r    <= onehot(win_idx_s);
                        gnt_id_r <= win_idx_s;
                        busy_r   <= 1'b1;
                        ptr_r    <= next_ptr(win_idx_s);
                        state_r  <= ST_GRANT;
                    end else begin
                        gnt_r    <= {N{1'b0}};
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if ((r_s & gnt_r) == {N{1'b0}}) begin
                        gnt_r    <= {N{1'b0}};
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        gnt_r    <= gnt_r;
                        busy_r   <= 1'b1;
                        state_r  <= ST_GRANT;
                    end
                end
                default: begin
                    gnt_r    <= {N{1'b0}};
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.gnt_id = gnt_id_r;
    assign bus.busy   = busy_r;
endmodule

// File: doc/teak_mutex_n.md
# teak_mutex_n

Clocked N-way mutual-exclusion arbiter with four-phase (return-to-zero) request/grant handshakes on every channel. It generalises the two-input MUTEX cell to N requesters and adds round-robin fairness and optional request synchronisers. It sits between self-timed handshake components and a shared clocked resource, granting at most one channel at a time.

## Interface
- N, default 2: number of requesting channels; legal range 2..16.
- SYNC_STAGES, default 2: flip-flop stages per request synchroniser; legal minimum 2; used only when TEAK_MUTEX_SYNC_EN is defined.
- GW, default $clog2(N): width of gnt_id; derived, not overridden.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N  four-phase request, one bit per channel.
- gnt  out  N  four-phase grant, one bit per channel; at most one bit high (one-hot or zero).
- gnt_id  out  GW  index of the current or most recent grantee.
- busy  out  1  high while any gnt bit is high.

## Operation
- The internal request vector r is req, or the synchronised req when TEAK_MUTEX_SYNC_EN is defined.
- The FSM has two states:
  - IDLE: all gnt low. If r is nonzero, select winner w, set gnt[w]=1, gnt_id=w, busy=1, ptr=(w+1) mod N, and go to GRANT. If r is zero, stay in IDLE.
  - GRANT: hold gnt[w]. When r[w]=0, clear gnt and busy and go to IDLE. gnt_id keeps w.
- Winner selection: the first set bit of r scanning upward from index ptr and wrapping past N-1 to 0. ptr resets to 0.
- Mutual exclusion: gnt is never multi-hot. Between two grants there is at least one cycle with gnt all-low, including a re-grant to the same channel.
- Requests from other channels raised during GRANT are held pending and do not affect the current grant.
- A request withdrawn before it is granted is not granted. This violates the protocol but is tolerated.
- If r[w] drops and another r is set in the same cycle, only the release is taken. Arbitration happens on the following edge.
- Registers: gnt, gnt_id, busy, state, ptr, plus synchroniser flops when enabled.

## Timing
- Reset (reset_n=0), asynchronous:
  - gnt=0, busy=0, gnt_id=0, ptr=0, state=IDLE.
  - All synchroniser flops cleared.
  - This applies mid-grant too: the grant is dropped immediately, with no handshake completion.
- Reset deassertion is synchronous in effect. The first arbitration can occur on the first rising edge with reset_n=1.
- Grant latency without sync: r[i] high at edge k, sampled in IDLE, gives gnt[i]=1 after edge k.
- Release latency without sync: r[i] low at edge m gives gnt[i]=0 after edge m.
- With sync, both latencies grow by SYNC_STAGES cycles.
- Minimum full handshake, without sync: 2 cycles per grant. Back-to-back throughput is one grant per 2 cycles when requesters respond combinationally.
- busy tracks |gnt exactly, on the same edge.

## Configuration
- TEAK_MUTEX_SYNC_EN:
  - Defined: each req bit passes through a SYNC_STAGES-deep flop chain clocked by clk and reset by reset_n. req may then be fully asynchronous to clk.
  - Undefined: r=req directly. req must be synchronous to clk, and SYNC_STAGES is ignored.

## Test plan
- Reset, then single request, N=4, no sync: req=0001 at edge 1 -> gnt=0001, busy=1, gnt_id=0 after edge 1. Drop req at edge 5 -> gnt=0000 after edge 5.
- Simultaneous requests: req=1111 held, each requester releasing one cycle after its grant -> grants in order 0,1,2,3,0, with one all-low cycle between each grant.
- Round-robin wrap: ptr=3 after granting 2, req=1001 -> channel 3 granted first, then 0. gnt_id shows 3 then 0.
- Pending request during grant: ch1 granted, ch0 raises req -> gnt stays 0010 until req[1]=0. gnt=0001 appears exactly one edge after gnt=0000.
- Reset mid-grant: gnt=0100, pull reset_n low between edges -> gnt=0, busy=0, gnt_id=0 immediately, without waiting for a clk edge. After release, req=0100 still high -> regranted after the first edge.
- With TEAK_MUTEX_SYNC_EN and SYNC_STAGES=3: req[0] rises -> gnt[0] rises after the 4th edge. The mutual-exclusion assertion (gnt never multi-hot) holds under 10k random asynchronous req toggles obeying the four-phase protocol.
